gate_sequencer: RTL and testbench
=================================

GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_valid  input  1  command request.
REQ-005 SHALL have port start_ready  output  1  command can be accepted.
REQ-006 SHALL have port op  input  3  gate select: 000 NOT a, 001 AND, 010 NAND, 011 OR, 100 NOR, 101 XOR, 110 XNOR, 111 illegal.
REQ-007 SHALL have port negate_b  input  1  when 1, use ~b in place of b.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port result  output  WIDTH  last completed result.
REQ-011 SHALL have port result_valid  output  1  result available.
REQ-012 SHALL have port result_ready  input  1  consumer accepts result.
REQ-013 SHALL have port illegal  output  1  completed command used op 111.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.
REQ-015 SHALL have port op_count  output  8  completed-command counter.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; start_ready = 1 only in IDLE; busy = 1 in RUN and DONE.
REQ-017 SHALL accept a command on a rising edge where start_valid & start_ready, capturing op, negate_b, a and b, clearing the bit index to 0, and moving IDLE -> RUN.
REQ-018 SHALL, in RUN, evaluate exactly one bit per cycle through a single 1-bit gate function, LSB first, and shift the bit into an internal accumulator.
REQ-019 SHALL ignore changes on a, b, op and negate_b after acceptance.
REQ-020 SHALL leave RUN after exactly WIDTH evaluation cycles; after the edge computing bit WIDTH-1: copy the accumulator to result, set illegal = (op == 111), increment op_count, enter DONE.
REQ-021 SHALL assert result_valid = 1 in DONE, starting WIDTH edges after the accept edge.
REQ-022 SHALL hold result, illegal and result_valid stable in DONE while result_ready = 0, with no cycle limit.
REQ-023 SHALL, on a DONE edge with result_ready = 1, drop result_valid and return to IDLE; start_ready rises on the following cycle, so no same-edge back-to-back accept occurs.
REQ-024 SHALL ignore start_valid outside IDLE.
REQ-025 SHALL produce bit i, for op 111, as 0 for all i, giving result all-zero.
REQ-026 SHALL hold result and illegal from the last completion outside DONE; they are cleared only by reset.
REQ-027 SHALL wrap op_count modulo 256 (255 -> 0), with no saturation.
REQ-028 SHALL ignore negate_b for op 000.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force: state IDLE, start_ready = 1, result_valid = 0, busy = 0, result = 0, illegal = 0, op_count = 0, bit index = 0, accumulator = 0.
REQ-030 SHALL, on reset mid-RUN or in DONE, discard the in-flight command with no completion and no op_count increment.
REQ-031 SHALL accept no command on the first rising edge after rst_n deasserts unless start_valid = 1 on that edge.

Verification (WIDTH = 8)
REQ-032 SHALL be verified for reset: hold rst_n = 0 mid-stream -> start_ready = 1, result_valid = 0, busy = 0, result = 8'h00, illegal = 0, op_count = 0.
REQ-033 SHALL be verified for AND: a = F0, b = CC, op = 001, negate_b = 0 -> result_valid high exactly 8 edges after accept, result = C0, illegal = 0, op_count = 1.
REQ-034 SHALL be verified for XOR with negation, then NOT: a = AA, b = 0F, op = 101, negate_b = 1 -> result = 5A; next, a = 3C, op = 000, negate_b = 1 -> result = C3.
REQ-035 SHALL be verified for backpressure: result_ready = 0 for 5 cycles in DONE, start_valid = 1 throughout -> result, result_valid and illegal stable, start_ready = 0, no new accept; result_ready = 1 -> IDLE, start_ready = 1 next cycle.
REQ-036 SHALL be verified for reset mid-RUN: assert rst_n = 0 after bit 3 -> immediate IDLE, result_valid = 0, op_count = 0, and prior result cleared to 00.
REQ-037 SHALL be verified for illegal op and counter wrap: op = 111 with a = FF, b = FF -> result = 00, illegal = 1; 256 completions from reset -> op_count = 0.

Source files
------------

// File: rtl/gate_sequencer.sv
// Bit-serial gate evaluator: evaluates one bit of the selected gate per cycle, LSB first.
// Latency: result_valid rises WIDTH edges after the accept edge; DONE holds the result until result_ready.
module gate_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic             negate_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             illegal,
    output logic             busy,
    output logic [7:0]       op_count
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic             accept;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             gate_bit;

    assign accept   = start_valid && start_ready;
    assign last_bit = (state == RUN) && (idx == LAST_IDX);
    assign a_bit    = a_q[idx];
    assign b_bit    = b_q[idx];

    // Single 1-bit gate shared by every bit position.
    always_comb begin
        gate_bit = 1'b0;
        case (op_q)
            3'b000:  gate_bit = ~a_bit;
            3'b001:  gate_bit = a_bit & b_bit;
            3'b010:  gate_bit = ~(a_bit & b_bit);
            3'b011:  gate_bit = a_bit | b_bit;
            3'b100:  gate_bit = ~(a_bit | b_bit);
            3'b101:  gate_bit = a_bit ^ b_bit;
            3'b110:  gate_bit = ~(a_bit ^ b_bit);
            default: gate_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE:    start_ready = 1'b1;
            RUN:     busy = 1'b1;
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            idx      <= '0;
            result   <= '0;
            illegal  <= 1'b0;
            op_count <= '0;
        end else if (accept) begin
            op_q <= op;
            a_q  <= a;
            // Operand B is stored already conditioned; NOT ignores it anyway.
            b_q  <= negate_b ? ~b : b;
            acc  <= '0;
            idx  <= '0;
        end else if (state == RUN) begin
            acc <= {gate_bit, acc[WIDTH-1:1]};
            if (last_bit) begin
                idx      <= '0;
                result   <= {gate_bit, acc[WIDTH-1:1]};
                illegal  <= (op_q == 3'b111);
                op_count <= op_count + 8'd1;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: word-level reference model checked every cycle, plus literal spot checks.
module tb_gate_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [2:0]   op = 3'b000;
    logic         negate_b = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         result_valid;
    logic         result_ready = 1'b1;
    logic         illegal;
    logic         busy;
    logic [7:0]   op_count;

    int vectors = 0;
    int miscompares = 0;

    gate_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .negate_b     (negate_b),
        .a            (a),
        .b            (b),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .illegal      (illegal),
        .busy         (busy),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gate_word(input logic [2:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input logic n);
        logic [W-1:0] yy;
        yy = n ? ~y : y;
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & yy;
            3'd2:    return ~(x & yy);
            3'd3:    return x | yy;
            3'd4:    return ~(x | yy);
            3'd5:    return x ^ yy;
            3'd6:    return ~(x ^ yy);
            default: return '0;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1 computing, 2 holding a result.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_word = '0;
    logic         m_will = 1'b0;
    logic [W-1:0] m_result = '0;
    logic         m_ill = 1'b0;
    logic [7:0]   m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_result = '0;
            m_ill    = 1'b0;
            m_cnt    = '0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                    m_word  = gate_word(op, a, b, negate_b);
                    m_will  = (op == 3'b111);
                    m_left  = W;
                    m_phase = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_result = m_word;
                        m_ill    = m_will;
                        m_cnt    = m_cnt + 8'd1;
                        m_phase  = 2;
                    end
                end
                default: if (result_ready) m_phase = 0;
            endcase
        end
    end

    initial begin
        #6;
        forever begin
            @(negedge clk);
            check("cycle",
                  {12'd0, start_ready, busy, result_valid, illegal, op_count, result},
                  {12'd0, m_phase == 0, m_phase != 0, m_phase == 2, m_ill, m_cnt, m_result});
        end
    end

    // Issues one command from IDLE; optionally stalls the consumer in DONE with start_valid held high.
    task automatic run_cmd(input logic [2:0] o, input logic n, input logic [W-1:0] x,
                           input logic [W-1:0] y, input int stall);
        logic [W-1:0] held;
        start_valid  = 1'b1;
        op           = o;
        negate_b     = n;
        a            = x;
        b            = y;
        result_ready = (stall == 0);
        @(posedge clk); #2;
        start_valid = (stall > 0);
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 3'($urandom);
        negate_b = 1'($urandom);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #2;
            check("latency_valid", result_valid, k == W);
        end
        held = result;
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #2;
                check("stall_valid", result_valid, 1);
                check("stall_ready", start_ready, 0);
                check("stall_result", result, held);
            end
            result_ready = 1'b1;
            start_valid  = 1'b0;
        end
        @(posedge clk); #2;
        check("back_to_idle", start_ready, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_start_ready", start_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 8'h00);
        check("rst_illegal", illegal, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("no_accept_after_rst", busy, 0);

        run_cmd(3'b001, 1'b0, 8'hF0, 8'hCC, 0);
        check("and_result", result, 8'hC0);
        check("and_illegal", illegal, 0);
        check("and_count", op_count, 1);

        run_cmd(3'b101, 1'b1, 8'hAA, 8'h0F, 0);
        check("xorn_result", result, 8'h5A);

        run_cmd(3'b000, 1'b1, 8'h3C, 8'h0F, 0);
        check("not_result", result, 8'hC3);
        check("not_count", op_count, 3);

        run_cmd(3'b011, 1'b0, 8'h12, 8'h34, 5);
        check("bp_result", result, 8'h36);
        check("bp_count", op_count, 4);

        run_cmd(3'b010, 1'b0, 8'hF0, 8'hCC, 0);
        check("nand_result", result, 8'h3F);
        run_cmd(3'b100, 1'b0, 8'hA0, 8'h05, 0);
        check("nor_result", result, 8'h5A);
        run_cmd(3'b111, 1'b0, 8'hFF, 8'hFF, 0);
        check("illegal_result", result, 8'h00);
        check("illegal_flag", illegal, 1);
        run_cmd(3'b110, 1'b0, 8'hF0, 8'hCC, 0);
        check("xnor_result", result, 8'hC3);
        check("xnor_clears_illegal", illegal, 0);

        // Abort mid-computation after bits 0..3.
        start_valid = 1'b1;
        op = 3'b011; negate_b = 1'b0; a = 8'h55; b = 8'h0F;
        @(posedge clk); #2;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_start_ready", start_ready, 1);
        check("midrun_valid", result_valid, 0);
        check("midrun_busy", busy, 0);
        check("midrun_count", op_count, 0);
        check("midrun_result", result, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("idle_after_release", start_ready, 1);

        for (int i = 0; i < 256; i++) begin
            run_cmd(3'($urandom), 1'($urandom), W'($urandom), W'($urandom), 0);
            if (i == 254) check("count_255", op_count, 8'd255);
        end
        check("count_wrap", op_count, 8'd0);

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
